tournament_predictor_q: RTL and testbench

Parametrised tournament branch predictor for the fetch stage: local-history predictor, global-history predictor and choice table, all built from saturating counters.
Replaces the fixed two-stage delayed-update pipeline with an in-order metadata queue, so any number of branches up to QDEPTH can be in flight.
Adds optional gshare indexing, speculative global-history update with checkpoint repair on mispredict, and statistics counters.

---
 rtl/tp_pkg.sv | 54 +++++
 rtl/tournament_predictor_q_if.sv | 39 +++
 rtl/sat_ctr_table.sv | 46 ++++
 rtl/tournament_predictor_q.sv | 185 ++++++++++++++++++
 tb/tb_tournament_predictor_q.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tp_pkg
//  Description : Shared types and helpers for the tournament predictor:
//                saturating counter step, global index hash, counter reset
//                value and the in-flight queue entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package tp_pkg;

    // Queue entry fields are stored at this fixed width; every index and
    // history width of the predictor must stay below it.
    localparam int C_MAX_W = 16;

    typedef struct packed {
        logic [C_MAX_W-1:0] lht_idx;   // local history table slot
        logic [C_MAX_W-1:0] lct_idx;   // local counter slot (history value)
        logic [C_MAX_W-1:0] gidx;      // global/choice counter slot
        logic [C_MAX_W-1:0] ghr_ckpt;  // GHR before this branch's bit
        logic               lpred;
        logic               gpred;
        logic               pred;
    } q_entry_t;

    // Weakly not-taken / weakly local counter value for a given width.
    function automatic logic [31:0] ctr_rst_val(input int bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

    // One saturating step toward up (increment) or down (decrement).
    function automatic logic [31:0] sat_step(input logic [31:0] val,
                                             input logic [31:0] max_val,
                                             input logic        up);
        if (up)
            return (val == max_val) ? val : val + 32'd1;
        else
            return (val == 32'd0) ? val : val - 32'd1;
    endfunction

    // Global/choice table index: plain GHR, or GHR xor word-aligned PC.
    function automatic logic [31:0] idx_hash(input logic [31:0] ghr,
                                             input logic [31:0] pc,
                                             input int          bits,
                                             input logic        gshare);
        logic [31:0] mask;
        mask = (32'd1 << bits) - 32'd1;
        if (gshare)
            return (ghr ^ (pc >> 2)) & mask;
        else
            return ghr & mask;
    endfunction

endpackage : tp_pkg
`default_nettype wire

// File: rtl/tournament_predictor_q_if.sv
`default_nettype none
// ============================================================================
//  Module      : tournament_predictor_q_if
//  Description : Request / resolve / status bundle of the tournament
//                predictor. master = fetch/branch unit side, slave = predictor.
//  Ports       : req_valid, req_pc, req_ready, pred_taken, pred_sel_global,
//                res_valid, res_taken, flush, res_err, occupancy,
//                cnt_branches, cnt_mispred
//  Revision    : 1.0 - initial release
// ============================================================================
interface tournament_predictor_q_if #(
    parameter int QDEPTH = 4
);
    logic                      req_valid;
    logic [31:0]               req_pc;
    logic                      req_ready;
    logic                      pred_taken;
    logic                      pred_sel_global;
    logic                      res_valid;
    logic                      res_taken;
    logic                      flush;
    logic                      res_err;
    logic [$clog2(QDEPTH):0]   occupancy;
    logic [31:0]               cnt_branches;
    logic [31:0]               cnt_mispred;

    modport master (
        output req_valid, req_pc, res_valid, res_taken,
        input  req_ready, pred_taken, pred_sel_global, flush, res_err,
               occupancy, cnt_branches, cnt_mispred
    );

    modport slave (
        input  req_valid, req_pc, res_valid, res_taken,
        output req_ready, pred_taken, pred_sel_global, flush, res_err,
               occupancy, cnt_branches, cnt_mispred
    );
endinterface : tournament_predictor_q_if
`default_nettype wire

// File: rtl/sat_ctr_table.sv
`default_nettype none
// ============================================================================
//  Module      : sat_ctr_table
//  Description : Table of saturating counters. One combinational read port;
//                one update port that steps the addressed counter up or down.
//  Ports       : clk, rst, rd_idx_i, rd_ctr_o, wr_en_i, wr_idx_i, wr_up_i
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_ctr_table
    import tp_pkg::*;
#(
    parameter int                  IDX_BITS = 10,
    parameter int                  CTR_BITS = 2,
    parameter logic [CTR_BITS-1:0] RST_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic [CTR_BITS-1:0] rd_ctr_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic                wr_up_i
);
    localparam int          DEPTH     = 1 << IDX_BITS;
    localparam logic [31:0] C_CTR_MAX = (32'd1 << CTR_BITS) - 32'd1;

    logic [CTR_BITS-1:0] w_mem [DEPTH];
    logic [CTR_BITS-1:0] wr_ctr_d;

    assign rd_ctr_o = w_mem[rd_idx_i];
    assign wr_ctr_d = CTR_BITS'(sat_step(32'(w_mem[wr_idx_i]), C_CTR_MAX, wr_up_i));

    // One register per entry so the whole table resets in a single cycle.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [CTR_BITS-1:0] ctr_q;
        always_ff @(posedge clk) begin
            if (rst)
                ctr_q <= RST_VAL;
            else if (wr_en_i && (wr_idx_i == IDX_BITS'(g)))
                ctr_q <= wr_ctr_d;
        end
        assign w_mem[g] = ctr_q;
    end

endmodule : sat_ctr_table
`default_nettype wire

// File: rtl/tournament_predictor_q.sv
`default_nettype none
// ============================================================================
//  Module      : tournament_predictor_q
//  Description : Tournament branch predictor (local + global + choice) with
//                an in-order metadata queue for in-flight branches,
//                speculative GHR with checkpoint repair, optional gshare.
//  Ports       : clk, rst, bus (tournament_predictor_q_if.slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module tournament_predictor_q
    import tp_pkg::*;
#(
    parameter int LIDX_BITS  = 10,
    parameter int LHIST_BITS = 10,
    parameter int GHIST_BITS = 12,
    parameter int CTR_BITS   = 2,
    parameter int QDEPTH     = 4,
    parameter int GSHARE     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    tournament_predictor_q_if.slave  bus
);
    localparam int                  PTR_W     = $clog2(QDEPTH);
    localparam int                  OCC_W     = PTR_W + 1;
    localparam int                  LHT_N     = 1 << LIDX_BITS;
    localparam logic [CTR_BITS-1:0] C_CTR_RST = CTR_BITS'(ctr_rst_val(CTR_BITS));
    localparam logic [OCC_W-1:0]    C_QDEPTH  = OCC_W'(QDEPTH);

    logic [GHIST_BITS-1:0] ghr_q, ghr_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]      count_q, count_d;
    logic [31:0]           cnt_br_q, cnt_mp_q;
    logic                  flush_q, res_err_q;
    q_entry_t              queue_q [QDEPTH];

    logic [LHIST_BITS-1:0] w_lht [LHT_N];
    logic [LIDX_BITS-1:0]  w_lht_idx, w_res_lht_idx;
    logic [LHIST_BITS-1:0] w_lct_idx, w_res_hist_d;
    logic [GHIST_BITS-1:0] w_gidx;
    logic [CTR_BITS-1:0]   w_lct_rd, w_gct_rd, w_cct_rd;
    logic                  w_lpred, w_gpred, w_choice, w_pred;
    logic                  w_empty, w_full, w_resolve, w_mispred, w_ready, w_accept;
    q_entry_t              w_head, w_push;
    logic                  w_unused;

    // ---------------- prediction (reads state before this cycle's update)
    assign w_lht_idx = bus.req_pc[LIDX_BITS+1:2];
    assign w_lct_idx = w_lht[w_lht_idx];
    assign w_gidx    = GHIST_BITS'(idx_hash(32'(ghr_q), bus.req_pc, GHIST_BITS, GSHARE != 0));
    assign w_lpred   = w_lct_rd[CTR_BITS-1];
    assign w_gpred   = w_gct_rd[CTR_BITS-1];
    assign w_choice  = w_cct_rd[CTR_BITS-1];
    assign w_pred    = w_choice ? w_gpred : w_lpred;

    // ---------------- queue control
    assign w_head    = queue_q[rd_ptr_q];
    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == C_QDEPTH);
    assign w_resolve = bus.res_valid & ~w_empty;
    assign w_mispred = w_resolve & (bus.res_taken != w_head.pred);
    // Requests are refused during a repair: the GHR is being rewritten.
    assign w_ready   = ~w_full & ~w_mispred;
    assign w_accept  = bus.req_valid & w_ready;

    assign w_res_lht_idx = w_head.lht_idx[LIDX_BITS-1:0];
    assign w_res_hist_d  = {w_lht[w_res_lht_idx][LHIST_BITS-2:0], bus.res_taken};

    // Upper entry bits are always zero; only the low slices are consumed.
    assign w_unused = ^{w_head.lht_idx[C_MAX_W-1:LIDX_BITS],
                        w_head.lct_idx[C_MAX_W-1:LHIST_BITS],
                        w_head.gidx[C_MAX_W-1:GHIST_BITS],
                        w_head.ghr_ckpt[C_MAX_W-1:GHIST_BITS-1]};

    always_comb begin
        w_push          = '0;
        w_push.lht_idx  = C_MAX_W'(w_lht_idx);
        w_push.lct_idx  = C_MAX_W'(w_lct_idx);
        w_push.gidx     = C_MAX_W'(w_gidx);
        w_push.ghr_ckpt = C_MAX_W'(ghr_q);
        w_push.lpred    = w_lpred;
        w_push.gpred    = w_gpred;
        w_push.pred     = w_pred;
    end

    always_comb begin
        ghr_d = ghr_q;
        if (w_mispred)
            ghr_d = {w_head.ghr_ckpt[GHIST_BITS-2:0], bus.res_taken};
        else if (w_accept)
            ghr_d = {ghr_q[GHIST_BITS-2:0], w_pred};
    end

    always_comb begin
        count_d = count_q;
        if (w_mispred)
            count_d = '0;
        else if (w_accept && !w_resolve)
            count_d = count_q + 1'b1;
        else if (!w_accept && w_resolve)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cnt_br_q  <= '0;
            cnt_mp_q  <= '0;
            flush_q   <= 1'b0;
            res_err_q <= 1'b0;
        end else begin
            ghr_q     <= ghr_d;
            count_q   <= count_d;
            flush_q   <= w_mispred;
            res_err_q <= bus.res_valid & w_empty;
            if (w_resolve)
                cnt_br_q <= cnt_br_q + 32'd1;
            if (w_mispred) begin
                cnt_mp_q <= cnt_mp_q + 32'd1;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (w_accept)
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                if (w_resolve)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only read while count_q says it is valid.
    always_ff @(posedge clk) begin
        if (w_accept)
            queue_q[wr_ptr_q] <= w_push;
    end

    // ---------------- local history table (updated non-speculatively)
    for (genvar g = 0; g < LHT_N; g++) begin : g_lht
        logic [LHIST_BITS-1:0] hist_q;
        always_ff @(posedge clk) begin
            if (rst)
                hist_q <= '0;
            else if (w_resolve && (w_res_lht_idx == LIDX_BITS'(g)))
                hist_q <= w_res_hist_d;
        end
        assign w_lht[g] = hist_q;
    end

    // ---------------- counter tables
    sat_ctr_table #(.IDX_BITS(LHIST_BITS), .CTR_BITS(CTR_BITS), .RST_VAL(C_CTR_RST)) u_lct (
        .clk(clk), .rst(rst),
        .rd_idx_i(w_lct_idx), .rd_ctr_o(w_lct_rd),
        .wr_en_i(w_resolve), .wr_idx_i(w_head.lct_idx[LHIST_BITS-1:0]), .wr_up_i(bus.res_taken)
    );

    sat_ctr_table #(.IDX_BITS(GHIST_BITS), .CTR_BITS(CTR_BITS), .RST_VAL(C_CTR_RST)) u_gct (
        .clk(clk), .rst(rst),
        .rd_idx_i(w_gidx), .rd_ctr_o(w_gct_rd),
        .wr_en_i(w_resolve), .wr_idx_i(w_head.gidx[GHIST_BITS-1:0]), .wr_up_i(bus.res_taken)
    );

    // Choice trains only on disagreement, toward the component that was right.
    sat_ctr_table #(.IDX_BITS(GHIST_BITS), .CTR_BITS(CTR_BITS), .RST_VAL(C_CTR_RST)) u_cct (
        .clk(clk), .rst(rst),
        .rd_idx_i(w_gidx), .rd_ctr_o(w_cct_rd),
        .wr_en_i(w_resolve & (w_head.lpred != w_head.gpred)),
        .wr_idx_i(w_head.gidx[GHIST_BITS-1:0]),
        .wr_up_i(w_head.gpred == bus.res_taken)
    );

    // ---------------- outputs
    assign bus.req_ready       = w_ready;
    assign bus.pred_taken      = w_pred;
    assign bus.pred_sel_global = w_choice;
    assign bus.flush           = flush_q;
    assign bus.res_err         = res_err_q;
    assign bus.occupancy       = count_q;
    assign bus.cnt_branches    = cnt_br_q;
    assign bus.cnt_mispred     = cnt_mp_q;

endmodule : tournament_predictor_q
`default_nettype wire

// File: tb/tb_tournament_predictor_q.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tournament_predictor_q
//  Description : Self-checking bench: reference model of the predictor kept
//                as plain integer tables and a queue, compared every cycle,
//                plus hand-computed literal expectations. A second instance
//                built with GSHARE=1 checks the hashed index.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tournament_predictor_q;

    localparam int QD  = 4;
    localparam int LN  = 1024;   // 2^LHIST_BITS and 2^LIDX_BITS
    localparam int GN  = 4096;   // 2^GHIST_BITS

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    tournament_predictor_q_if #(.QDEPTH(QD)) if0 ();
    tournament_predictor_q_if #(.QDEPTH(QD)) if1 ();

    tournament_predictor_q #(.GSHARE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    tournament_predictor_q #(.GSHARE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (GSHARE=0 instance)
    typedef struct {
        int lhi; int lci; int gi; int ck;
        bit lp;  bit gp;  bit p;  bit ch;
    } ment_t;

    int    m_lht [LN];
    int    m_lct [LN];
    int    m_gct [GN];
    int    m_cct [GN];
    int    m_ghr;
    int    m_cb, m_cm;
    bit    m_flush, m_err, m_ok;
    ment_t m_q [$];

    function automatic int towards(input int v, input bit up);
        if (up) return (v < 3) ? v + 1 : 3;
        return (v > 0) ? v - 1 : 0;
    endfunction

    function automatic ment_t m_predict(input logic [31:0] pc);
        ment_t e;
        e.lhi = int'((pc >> 2) % LN);
        e.lci = m_lht[e.lhi];
        e.gi  = m_ghr;
        e.ck  = m_ghr;
        e.lp  = (m_lct[e.lci] >= 2);
        e.gp  = (m_gct[e.gi] >= 2);
        e.ch  = (m_cct[e.gi] >= 2);
        e.p   = e.ch ? e.gp : e.lp;
        return e;
    endfunction

    task automatic model_step();
        ment_t e, h;
        bit emp, res, mis, acc;
        if (rst) begin
            foreach (m_lht[i]) m_lht[i] = 0;
            foreach (m_lct[i]) m_lct[i] = 1;
            foreach (m_gct[i]) m_gct[i] = 1;
            foreach (m_cct[i]) m_cct[i] = 1;
            m_ghr = 0; m_cb = 0; m_cm = 0; m_flush = 0; m_err = 0;
            m_q.delete();
            m_ok = 1;
            return;
        end
        e   = m_predict(if0.req_pc);
        emp = (m_q.size() == 0);
        res = if0.res_valid && !emp;
        mis = 0;
        if (res) begin
            h   = m_q[0];
            mis = (h.p != if0.res_taken);
        end
        acc     = if0.req_valid && (m_q.size() < QD) && !mis;
        m_err   = if0.res_valid && emp;
        m_flush = mis;
        if (res) begin
            m_lct[h.lci] = towards(m_lct[h.lci], if0.res_taken);
            m_gct[h.gi]  = towards(m_gct[h.gi], if0.res_taken);
            if (h.lp != h.gp)
                m_cct[h.gi] = towards(m_cct[h.gi], h.gp == if0.res_taken);
            m_lht[h.lhi] = ((m_lht[h.lhi] << 1) | int'(if0.res_taken)) % LN;
            void'(m_q.pop_front());
            m_cb++;
            if (mis) begin
                m_q.delete();
                m_ghr = ((h.ck << 1) | int'(if0.res_taken)) % GN;
                m_cm++;
            end
        end
        if (acc) begin
            m_q.push_back(e);
            m_ghr = ((m_ghr << 1) | int'(e.p)) % GN;
        end
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        ment_t e;
        bit mis;
        e   = m_predict(if0.req_pc);
        mis = 0;
        if (if0.res_valid && m_q.size() != 0)
            mis = (m_q[0].p != if0.res_taken);
        check("pred_taken",      if0.pred_taken,      e.p);
        check("pred_sel_global", if0.pred_sel_global, e.ch);
        check("req_ready",       if0.req_ready,       (m_q.size() < QD) && !mis);
        check("occupancy",       if0.occupancy,       m_q.size());
        check("flush",           if0.flush,           m_flush);
        check("res_err",         if0.res_err,         m_err);
        check("cnt_branches",    if0.cnt_branches,    m_cb);
        check("cnt_mispred",     if0.cnt_mispred,     m_cm);
        check("ghr",             dut0.ghr_q,          m_ghr);
    endtask

    initial begin
        m_ok = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok && !rst) compare();
        end
    end

    // ---------------- stimulus
    task automatic step(input bit rv, input logic [31:0] pc, input bit sv, input bit st);
        @(posedge clk); #1;
        if0.req_valid = rv; if0.req_pc = pc; if0.res_valid = sv; if0.res_taken = st;
    endtask

    task automatic step1(input bit rv, input logic [31:0] pc, input bit sv, input bit st);
        @(posedge clk); #1;
        if1.req_valid = rv; if1.req_pc = pc; if1.res_valid = sv; if1.res_taken = st;
    endtask

    logic [63:0] pat;

    initial begin
        rst = 1'b1;
        if0.req_valid = 0; if0.req_pc = '0; if0.res_valid = 0; if0.res_taken = 0;
        if1.req_valid = 0; if1.req_pc = '0; if1.res_valid = 0; if1.res_taken = 0;
        pat = 64'hB5C3_96E1_7A2D_4F08;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, PC 0x100 shown but not requested.
        step(0, 32'h100, 0, 0); #1;
        check("rst_pred_taken", if0.pred_taken, 0);
        check("rst_sel_global", if0.pred_sel_global, 0);
        check("rst_req_ready",  if0.req_ready, 1);
        check("rst_occupancy",  if0.occupancy, 0);
        check("rst_ghr",        dut0.ghr_q, 0);

        // Five predict/resolve pairs, all not-taken.
        for (int k = 0; k < 5; k++) begin
            step(1, 32'h200, 0, 0); #1;
            check("nt_pair_pred", if0.pred_taken, 0);
            step(0, 32'h200, 1, 0);
        end
        step(0, 32'h0, 0, 0); #1;
        check("nt_lct0",   dut0.u_lct.w_mem[0], 0);
        check("nt_gct0",   dut0.u_gct.w_mem[0], 0);
        check("nt_ghr",    dut0.ghr_q, 0);
        check("nt_cnt_br", if0.cnt_branches, 5);
        check("nt_cnt_mp", if0.cnt_mispred, 0);

        // Fill the queue; the fifth request is refused.
        repeat (4) step(1, 32'h100, 0, 0);
        step(1, 32'h100, 0, 0); #1;
        check("full_occ",   if0.occupancy, 4);
        check("full_ready", if0.req_ready, 0);
        step(0, 32'h100, 0, 0); #1;
        check("full_occ_after", if0.occupancy, 4);
        check("full_ghr",       dut0.ghr_q, 0);

        // One correct resolve leaves three in flight, then a mispredict.
        step(0, 32'h100, 1, 0);
        step(1, 32'h100, 1, 1); #1;
        check("mis_ready", if0.req_ready, 0);
        step(0, 32'h0, 0, 0); #1;
        check("mis_flush",   if0.flush, 1);
        check("mis_occ",     if0.occupancy, 0);
        check("mis_ghr",     dut0.ghr_q, 1);
        check("mis_cnt_mp",  if0.cnt_mispred, 1);
        check("mis_cnt_br",  if0.cnt_branches, 7);
        check("mis_lht",     dut0.w_lht[64], 1);
        check("mis_cct0",    dut0.u_cct.w_mem[0], 1);
        check("mis_lct0",    dut0.u_lct.w_mem[0], 1);

        // Occupancy 2 with simultaneous accept and correct resolve.
        step(1, 32'h300, 0, 0);
        step(1, 32'h300, 0, 0);
        step(1, 32'h300, 1, 0); #1;
        check("sim_ghr_before", dut0.ghr_q, 4);
        step(0, 32'h0, 0, 0); #1;
        check("sim_occ",   if0.occupancy, 2);
        check("sim_ghr",   dut0.ghr_q, 8);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);

        // Resolve against an empty queue.
        step(0, 32'h0, 1, 1);
        step(0, 32'h0, 0, 0); #1;
        check("err_pulse",  if0.res_err, 1);
        check("err_cnt_br", if0.cnt_branches, 10);
        check("err_cnt_mp", if0.cnt_mispred, 1);
        check("err_ghr",    dut0.ghr_q, 8);
        check("err_flush",  if0.flush, 0);
        step(0, 32'h0, 0, 0); #1;
        check("err_clear",  if0.res_err, 0);

        // Gshare instance: PC 0x4 with GHR 0 maps to entry 1.
        step1(1, 32'h4, 0, 0); #1;
        check("gs_pred", if1.pred_taken, 0);
        check("gs_sel",  if1.pred_sel_global, 0);
        step1(0, 32'h4, 1, 0);
        step1(0, 32'h0, 0, 0); #1;
        check("gs_gct1",   dut1.u_gct.w_mem[1], 0);
        check("gs_gct0",   dut1.u_gct.w_mem[0], 1);
        check("gs_occ",    if1.occupancy, 0);
        check("gs_ghr",    dut1.ghr_q, 0);
        check("gs_cnt_br", if1.cnt_branches, 1);

        // Mixed traffic: pipelined requests and resolves, model-checked.
        for (int i = 0; i < 40; i++)
            step(1, 32'h400 + 32'(4 * (i % 4)), i > 0, pat[i]);
        repeat (3) step(0, 32'h0, 0, 0);
        @(posedge clk); #2;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tournament_predictor_q
`default_nettype wire
